dot_product_sequencer: RTL and testbench
========================================

# dot_product_sequencer

Streaming dot-product engine: accepts a job length on a start pulse, consumes that many operand pairs over a valid/ready handshake, and sequences a two-stage multiply-accumulate pipeline. It returns the sum on a result valid/ready handshake. It is the controller-plus-datapath that replaces hand-timed load/clear strobes. Upstream operand sources and a downstream result consumer connect to it directly.

## Interface
- DATA_W, 7, unsigned operand width
- LEN_W, 4, job-length width; max job = 2^LEN_W-1 pairs
- ACC_W, 2*DATA_W+LEN_W, accumulator/result width (derived, overflow-free)
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  job request, sampled only in IDLE
- len  input  LEN_W  pair count, captured with start
- in_valid  input  1  operand pair valid
- in_ready  output  1  sequencer accepts pair
- a_in, b_in  input  DATA_W  operands
- result_valid  output  1  result available
- result_ready  input  1  consumer takes result
- result  output  ACC_W  dot-product sum
- busy  output  1  state != IDLE
- abort  input  1  present only with DOTP_ABORT_EN

## Operation
- States: IDLE, CLEAR, LOAD, DRAIN, DONE.
- IDLE: start=1 -> CLEAR; cnt <= len. start is ignored in every other state.
- CLEAR (1 cycle): acc <= 0, p_vld <= 0. Next state is DONE if cnt==0, else LOAD.
- LOAD: in_ready=1. Each cycle with in_valid&in_ready: prod <= a_in*b_in, p_vld <= 1, cnt <= cnt-1. Acceptance at cnt==1 -> DRAIN. No accept -> p_vld <= 0, stay.
- Stage 2, every state: p_vld=1 -> acc <= acc + prod.
- DRAIN (1 cycle): in_ready=0; the final product is accumulated; next state is DONE.
- DONE: result_valid=1, result=acc held stable. result_ready=1 -> IDLE in the same cycle's edge. acc is retained until the next CLEAR.
- Arithmetic: unsigned. prod is 2*DATA_W bits and is zero-extended to ACC_W. Overflow cannot occur by construction.
- Reset values: state=IDLE, in_ready=0, result_valid=0, result=0, busy=0, acc=0, prod=0, p_vld=0, cnt=0.
- Async reset mid-job discards the job. After release, the block is in IDLE with no partial result.

## Timing
- start at edge E0 -> CLEAR during cycle after E0 -> in_ready high from E0+2.
- Back-to-back pairs: one per cycle with no bubbles. Latency from the last pair accepted at edge E to result_valid=1 is cycle E+2 (DRAIN, then DONE).
- Minimum job (len=1, in_valid held): start to result_valid = 4 cycles.
- len=0: result_valid=1 with result=0 two cycles after start.
- in_valid gaps in LOAD stall without loss; the handshake is purely registered on the state.
- result_valid stays high and result stays stable until result_ready. result_ready in the DONE-entry cycle is honoured immediately.
- busy falls on the edge that leaves DONE. A new start is accepted from the following cycle.

## Configuration
- DOTP_ABORT_EN defined: abort port exists. abort=1 in any non-IDLE state -> IDLE next edge, p_vld <= 0, no result_valid. abort has priority over a simultaneous pair accept or result handshake.
- DOTP_ABORT_EN undefined: no abort port. A job can end only through DONE or reset.

## Structure
- Package dotp_pkg: state enum (IDLE, CLEAR, LOAD, DRAIN, DONE), default DATA_W/LEN_W constants, ACC_W derivation function.
- Sub-module dotp_mac: prod/p_vld register stage plus accumulator, with clear and accept inputs. The sequencer holds only the FSM, the counter and the handshakes.

## Test plan
- len=3, pairs (2,3),(4,5),(6,7) back-to-back -> result_valid 2 cycles after the third accept, result=68.
- len=2, in_valid toggling 1,0,0,1 with pairs (127,127),(127,127) -> result=32258, no extra accumulation during gaps.
- len=0 -> result=0, result_valid two cycles after start, in_ready never asserted.
- result_ready held low 5 cycles in DONE -> result stable; start pulses during the job are ignored; a next job's result excludes the previous sum.
- rst_n low mid-LOAD after 2 of 4 pairs -> all outputs reset immediately; a new len=1 job (3,3) then yields 9.
- (DOTP_ABORT_EN) abort during DRAIN -> IDLE, result_valid never rises; a subsequent job is correct.

Source files
------------

// File: rtl/dotp_pkg.sv
// Shared types and sizing for the dot-product sequencer: FSM state encoding,
// default operand/length widths and the overflow-free accumulator width.
package dotp_pkg;

    localparam int DOTP_DATA_W = 7;
    localparam int DOTP_LEN_W  = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Up to 2^len_w-1 products of 2*data_w bits can never overflow this width.
    function automatic int acc_width(input int data_w, input int len_w);
        return 2 * data_w + len_w;
    endfunction

endpackage

// File: rtl/dotp_mac.sv
// Two-stage multiply-accumulate: stage 1 registers the product of an accepted
// pair, stage 2 folds a valid product into the accumulator.
module dotp_mac #(
    parameter int DATA_W = 7,
    parameter int ACC_W  = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    localparam int PROD_W = 2 * DATA_W;

    logic [PROD_W-1:0] prod;
    logic              p_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod  <= '0;
            p_vld <= 1'b0;
            acc   <= '0;
        end else begin
            if (accept) begin
                prod <= PROD_W'(a) * PROD_W'(b);
            end
            // p_vld tracks accepts only, so stalls and aborts never re-add prod.
            p_vld <= accept & ~clear;
            if (clear) begin
                acc <= '0;
            end else if (p_vld) begin
                acc <= acc + ACC_W'(prod);
            end
        end
    end

endmodule

// File: rtl/dot_product_sequencer.sv
// Job controller for the streaming dot product: FSM, pair counter and the
// operand/result handshakes. Optional abort input enabled by DOTP_ABORT_EN.
module dot_product_sequencer
    import dotp_pkg::*;
#(
    parameter int DATA_W = DOTP_DATA_W,
    parameter int LEN_W  = DOTP_LEN_W,
    parameter int ACC_W  = acc_width(DOTP_DATA_W, DOTP_LEN_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
`ifdef DOTP_ABORT_EN
    input  logic              abort,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [ACC_W-1:0]  result,
    output logic              busy,
    output state_t            fsm_state
);

    // Handshakes: a transfer happens on a rising edge where both valid and
    // ready are high; ready/valid from this block depend only on state (and
    // abort, which withdraws them), never on the partner's valid/ready.

    state_t           state, state_next;
    logic [LEN_W-1:0] cnt, cnt_next;
    logic             abort_hit;
    logic             accept;
    logic             clear;

`ifdef DOTP_ABORT_EN
    assign abort_hit = abort & (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign in_ready     = (state == LOAD) & ~abort_hit;
    assign result_valid = (state == DONE) & ~abort_hit;
    assign busy         = (state != IDLE);
    assign fsm_state    = state;
    assign accept       = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CLEAR;
                    cnt_next   = len;
                end
            end
            CLEAR: begin
                clear      = 1'b1;
                state_next = (cnt == '0) ? DONE : LOAD;
            end
            LOAD: begin
                if (accept) begin
                    cnt_next = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: state_next = DONE;
            DONE: begin
                if (result_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (abort_hit) begin
            state_next = IDLE;
        end
    end

    dotp_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .accept (accept),
        .a      (a_in),
        .b      (b_in),
        .acc    (result)
    );

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed and randomized jobs for dot_product_sequencer, checked against a
// plain sum-of-products model and the documented cycle timing.
module tb_dot_product_sequencer;
    import dotp_pkg::*;

    localparam int DATA_W = DOTP_DATA_W;
    localparam int LEN_W  = DOTP_LEN_W;
    localparam int ACC_W  = acc_width(DOTP_DATA_W, DOTP_LEN_W);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len = '0;
`ifdef DOTP_ABORT_EN
    logic              abort = 1'b0;
`endif
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] a_in = '0;
    logic [DATA_W-1:0] b_in = '0;
    logic              result_valid;
    logic              result_ready = 1'b0;
    logic [ACC_W-1:0]  result;
    logic              busy;
    state_t            fsm_state;

    dot_product_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .len          (len),
`ifdef DOTP_ABORT_EN
        .abort        (abort),
`endif
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .busy         (busy),
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [ACC_W-1:0]  exp_q[$];
    logic              vpat[$];
    logic [DATA_W-1:0] pa[16];
    logic [DATA_W-1:0] pb[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // One complete job: model sum, timing checks through LOAD/DRAIN/DONE.
    task automatic do_job(input int n, input int hold, input bit rand_gap);
        int s;
        int accepted;
        int budget;
        logic v;
        logic [ACC_W-1:0] exp_v;
        s = 0;
        for (int i = 0; i < n; i++) s += int'(pa[i]) * int'(pb[i]);
        exp_q.push_back(ACC_W'(s));

        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        check("clear_busy", 32'(busy), 1);
        check("clear_in_ready", 32'(in_ready), 0);
        tick();

        accepted = 0;
        budget   = 0;
        while (accepted < n && budget < 100) begin
            check("load_in_ready", 32'(in_ready), 1);
            check("load_result_valid", 32'(result_valid), 0);
            if (vpat.size() > 0) v = vpat.pop_front();
            else v = rand_gap ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_valid = v;
            a_in  = pa[accepted];
            b_in  = pb[accepted];
            start = 1'($urandom_range(0, 1));
            len   = LEN_W'($urandom_range(0, 15));
            tick();
            if (v) accepted++;
            budget++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (accepted < n) begin
            check("accept_timeout", 32'(accepted), 32'(n));
            return;
        end

        if (n > 0) begin
            check("drain_in_ready", 32'(in_ready), 0);
            check("drain_result_valid", 32'(result_valid), 0);
            tick();
        end

        exp_v = exp_q.pop_front();
        check("done_result_valid", 32'(result_valid), 1);
        check("done_result", 32'(result), 32'(exp_v));
        check("done_state", 32'(fsm_state), 32'(DONE));
        check("done_in_ready", 32'(in_ready), 0);
        for (int k = 0; k < hold; k++) begin
            result_ready = 1'b0;
            start = 1'($urandom_range(0, 1));
            tick();
            check("hold_result_valid", 32'(result_valid), 1);
            check("hold_result", 32'(result), 32'(exp_v));
        end
        start        = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("post_busy", 32'(busy), 0);
        check("post_result_valid", 32'(result_valid), 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_result_valid", 32'(result_valid), 0);
        check("rst_result", 32'(result), 0);
        rst_n = 1'b1;
        tick();

        // len=3 back-to-back -> 2*3+4*5+6*7 = 68
        pa[0] = 2; pb[0] = 3; pa[1] = 4; pb[1] = 5; pa[2] = 6; pb[2] = 7;
        do_job(3, 0, 1'b0);

        // stall gaps must not re-accumulate -> 2*127*127 = 32258
        pa[0] = 127; pb[0] = 127; pa[1] = 127; pb[1] = 127;
        vpat.push_back(1'b1); vpat.push_back(1'b0);
        vpat.push_back(1'b0); vpat.push_back(1'b1);
        do_job(2, 0, 1'b0);

        do_job(0, 0, 1'b0);

        // held result, then a fresh job must exclude the previous sum
        pa[0] = 10; pb[0] = 11; pa[1] = 12; pb[1] = 13;
        do_job(2, 5, 1'b0);
        pa[0] = 1; pb[0] = 1;
        do_job(1, 0, 1'b0);

        // maximum-length job with maximum operands
        for (int i = 0; i < 15; i++) begin pa[i] = 127; pb[i] = 127; end
        do_job(15, 1, 1'b1);

        for (int j = 0; j < 8; j++) begin
            n = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) begin
                pa[i] = DATA_W'($urandom_range(0, 127));
                pb[i] = DATA_W'($urandom_range(0, 127));
            end
            do_job(n, $urandom_range(0, 4), 1'b1);
        end

        // asynchronous reset in the middle of LOAD
        start = 1'b1; len = 4;
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1; a_in = 50; b_in = 60;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_in_ready", 32'(in_ready), 0);
        check("midrst_result_valid", 32'(result_valid), 0);
        check("midrst_result", 32'(result), 0);
        check("midrst_state", 32'(fsm_state), 32'(IDLE));
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pa[0] = 3; pb[0] = 3;
        do_job(1, 0, 1'b0);

`ifdef DOTP_ABORT_EN
        start = 1'b1; len = 2;
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1; a_in = 5; b_in = 7;
        tick();
        a_in = 6; b_in = 8;
        tick();
        in_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        for (int k = 0; k < 3; k++) begin
            check("abort_result_valid", 32'(result_valid), 0);
            tick();
        end
        pa[0] = 9; pb[0] = 9; pa[1] = 2; pb[1] = 4;
        do_job(2, 1, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
